// File: rtl/cbfp_pkg.sv
// Shared types and defaults for the CBFP delay buffer: sample, lane vector and stored entry layout.
package cbfp_pkg;

    localparam int DATA_WIDTH_DEF = 9;
    localparam int NUM_LANES_DEF  = 16;
    localparam int TAG_WIDTH_DEF  = 5;
    localparam int MAX_DEPTH_DEF  = 16;

    typedef logic signed [DATA_WIDTH_DEF-1:0] sample_t;
    typedef sample_t [NUM_LANES_DEF-1:0]      lane_vec_t;

    // Field order matches the flat word stored by cbfp_delay_buf: {i, q, tag}.
    typedef struct packed {
        lane_vec_t                 i;
        lane_vec_t                 q;
        logic [TAG_WIDTH_DEF-1:0]  tag;
    } entry_t;

    // Depth need not be a power of two, so wrap explicitly at depth-1.
    function automatic int unsigned ptr_next(int unsigned ptr, int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/cbfp_buf_ctrl.sv
// Pointer, occupancy and accept control for the CBFP delay buffer, including sticky error flags.
module cbfp_buf_ctrl
    import cbfp_pkg::*;
#(
    parameter int MAX_DEPTH = MAX_DEPTH_DEF,
    parameter int PTR_W     = $clog2(MAX_DEPTH),
    parameter int CNT_W     = $clog2(MAX_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    output logic             wr_en,
    output logic             rd_en,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             push_acc, pop_acc;

    assign full  = (count_q == CNT_W'(MAX_DEPTH));
    assign empty = (count_q == '0);

    // Pop is resolved first so a full buffer can accept a push in the same cycle it pops.
    always_comb begin
        pop_acc     = pop & ~empty & ~clr;
        push_acc    = push & (~full | pop_acc) & ~clr;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (push_acc) wr_ptr_d = PTR_W'(ptr_next(32'(wr_ptr_q), 32'(MAX_DEPTH)));
            if (pop_acc)  rd_ptr_d = PTR_W'(ptr_next(32'(rd_ptr_q), 32'(MAX_DEPTH)));
            case ({push_acc, pop_acc})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            overflow_d  = overflow_q  | (push & ~push_acc);
            underflow_d = underflow_q | (pop  & ~pop_acc);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign wr_en     = push_acc;
    assign rd_en     = pop_acc;
    assign wr_ptr    = wr_ptr_q;
    assign rd_ptr    = rd_ptr_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: rtl/cbfp_delay_buf.sv
// Multi-lane I/Q circular delay buffer with per-entry block-exponent tag and registered pop output.
module cbfp_delay_buf
    import cbfp_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_LANES  = NUM_LANES_DEF,
    parameter int MAX_DEPTH  = MAX_DEPTH_DEF,
    parameter int TAG_WIDTH  = TAG_WIDTH_DEF,
    parameter int CNT_W      = $clog2(MAX_DEPTH + 1)
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              clr,
    input  logic                              push,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]   din_i,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]   din_q,
    input  logic [TAG_WIDTH-1:0]              din_tag,
    input  logic                              pop,
    output logic                              dout_valid,
    output logic [NUM_LANES*DATA_WIDTH-1:0]   dout_i,
    output logic [NUM_LANES*DATA_WIDTH-1:0]   dout_q,
    output logic [TAG_WIDTH-1:0]              dout_tag,
    output logic [CNT_W-1:0]                  count,
    output logic                              full,
    output logic                              empty,
    output logic                              overflow,
    output logic                              underflow
);

    localparam int LW      = NUM_LANES * DATA_WIDTH;
    localparam int ENTRY_W = 2 * LW + TAG_WIDTH;
    localparam int PTR_W   = $clog2(MAX_DEPTH);

    logic               wr_en, rd_en;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [ENTRY_W-1:0] mem_q [MAX_DEPTH];
    logic [ENTRY_W-1:0] out_entry_q, out_entry_d;
    logic               out_valid_q, out_valid_d;

    cbfp_buf_ctrl #(
        .MAX_DEPTH (MAX_DEPTH),
        .PTR_W     (PTR_W),
        .CNT_W     (CNT_W)
    ) u_ctrl (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (clr),
        .push      (push),
        .pop       (pop),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    // Storage is deliberately not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr] <= {din_i, din_q, din_tag};
    end

    // rd_en is already masked by clr, so a flush also zeroes the output register.
    always_comb begin
        out_valid_d = rd_en;
        out_entry_d = '0;
        if (rd_en) out_entry_d = mem_q[rd_ptr];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            out_entry_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_entry_q <= out_entry_d;
        end
    end

    assign dout_valid                 = out_valid_q;
    assign {dout_i, dout_q, dout_tag} = out_entry_q;

endmodule

// File: tb/tb_cbfp_delay_buf.sv
// Bench for cbfp_delay_buf: directed vector table, queue-model sequences and a depth-5 wrap test.
module tb_cbfp_delay_buf;
    import cbfp_pkg::*;

    localparam int DW  = 9;
    localparam int NL  = 16;
    localparam int TW  = 5;
    localparam int LW  = NL * DW;
    localparam int D   = 16;
    localparam int D5  = 5;
    localparam int CW  = 5;
    localparam int CW5 = 3;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic          clr = 0, push = 0, pop = 0;
    logic [LW-1:0] din_i = '0, din_q = '0;
    logic [TW-1:0] din_tag = '0;
    logic          o_valid, o_full, o_empty, o_ovf, o_unf;
    logic [LW-1:0] o_i, o_q;
    logic [TW-1:0] o_tag;
    logic [CW-1:0] o_cnt;

    logic           clr5 = 0, push5 = 0, pop5 = 0;
    logic           v5, f5, e5, ov5, un5;
    logic [LW-1:0]  i5, q5o;
    logic [TW-1:0]  t5;
    logic [CW5-1:0] c5;

    cbfp_delay_buf #(.MAX_DEPTH(D)) dut (
        .clk(clk), .rstn(rstn), .clr(clr), .push(push),
        .din_i(din_i), .din_q(din_q), .din_tag(din_tag), .pop(pop),
        .dout_valid(o_valid), .dout_i(o_i), .dout_q(o_q), .dout_tag(o_tag),
        .count(o_cnt), .full(o_full), .empty(o_empty),
        .overflow(o_ovf), .underflow(o_unf)
    );

    cbfp_delay_buf #(.MAX_DEPTH(D5)) dut5 (
        .clk(clk), .rstn(rstn), .clr(clr5), .push(push5),
        .din_i(din_i), .din_q(din_q), .din_tag(din_tag), .pop(pop5),
        .dout_valid(v5), .dout_i(i5), .dout_q(q5o), .dout_tag(t5),
        .count(c5), .full(f5), .empty(e5),
        .overflow(ov5), .underflow(un5)
    );

    int ncmp = 0;
    int nerr = 0;

    task automatic chk(string nm, logic [LW-1:0] act, logic [LW-1:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] mk_i(int base);
        logic [LW-1:0] v;
        for (int l = 0; l < NL; l++) v[l*DW +: DW] = DW'(base + l);
        return v;
    endfunction

    function automatic logic [LW-1:0] mk_q(int base);
        logic [LW-1:0] v;
        for (int l = 0; l < NL; l++) v[l*DW +: DW] = DW'(-(base + l));
        return v;
    endfunction

    function automatic logic [LW-1:0] rnd_vec();
        logic [LW-1:0] v;
        for (int l = 0; l < NL; l++) begin
            case ($urandom % 4)
                0:       v[l*DW +: DW] = 9'h100;
                1:       v[l*DW +: DW] = 9'h0FF;
                default: v[l*DW +: DW] = DW'($urandom_range(0, 511));
            endcase
        end
        return v;
    endfunction

    // Reference model: a plain FIFO of entries plus sticky flags.
    entry_t mq[$];
    bit     m_ovf, m_unf, m_valid;
    entry_t m_out;

    task automatic check_model(string nm);
        chk({nm, " count"},  LW'(o_cnt),   LW'(mq.size()));
        chk({nm, " full"},   LW'(o_full),  LW'(mq.size() == D));
        chk({nm, " empty"},  LW'(o_empty), LW'(mq.size() == 0));
        chk({nm, " ovf"},    LW'(o_ovf),   LW'(m_ovf));
        chk({nm, " unf"},    LW'(o_unf),   LW'(m_unf));
        chk({nm, " valid"},  LW'(o_valid), LW'(m_valid));
        chk({nm, " dout_i"}, o_i,          LW'(m_out.i));
        chk({nm, " dout_q"}, o_q,          LW'(m_out.q));
        chk({nm, " tag"},    LW'(o_tag),   LW'(m_out.tag));
    endtask

    task automatic drive(bit p, bit r, bit c, logic [LW-1:0] di, logic [LW-1:0] dq,
                         logic [TW-1:0] dt, string nm);
        entry_t e;
        bit popok, pushok;
        push = p; pop = r; clr = c; din_i = di; din_q = dq; din_tag = dt;
        m_out = '0;
        if (c) begin
            mq.delete();
            m_ovf = 0; m_unf = 0; m_valid = 0;
        end else begin
            popok  = r && mq.size() > 0;
            pushok = p && (mq.size() < D || popok);
            if (r && !popok) m_unf = 1;
            if (p && !pushok) m_ovf = 1;
            m_valid = popok;
            if (popok) m_out = mq.pop_front();
            if (pushok) begin
                e.i = di; e.q = dq; e.tag = dt;
                mq.push_back(e);
            end
        end
        @(posedge clk); #1;
        check_model(nm);
    endtask

    task automatic push_k(int k, string nm);
        drive(1, 0, 0, mk_i(16*k), mk_q(16*k), TW'(k), nm);
    endtask

    typedef struct {
        bit push, pop;
        int k;
        int e_cnt;
        bit e_full, e_empty, e_valid, e_unf;
        int e_k;
    } vec_t;
    vec_t tbl[33];

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, got running want done");
        $fatal(1);
    end

    initial begin
        logic [LW-1:0] ei, eq;
        int q5m[$];
        int pushed, npop5, expk;
        bit p, r, popok, pushok;

        for (int k = 0; k < 16; k++)
            tbl[k] = '{1, 0, k, k+1, k == 15, 0, 0, 0, 0};
        for (int j = 0; j < 16; j++)
            tbl[16+j] = '{0, 1, 0, 15-j, 0, j == 15, 1, 0, j};
        tbl[32] = '{0, 1, 0, 0, 0, 1, 0, 1, 0};

        #12 rstn = 1'b1;
        chk("reset count", LW'(o_cnt),   '0);
        chk("reset empty", LW'(o_empty), LW'(1));
        chk("reset full",  LW'(o_full),  '0);
        chk("reset valid", LW'(o_valid), '0);
        chk("reset flags", LW'({o_ovf, o_unf}), '0);
        chk("reset dout",  o_i | o_q | LW'(o_tag), '0);

        foreach (tbl[n]) begin
            push = tbl[n].push; pop = tbl[n].pop; clr = 0;
            din_i = mk_i(16*tbl[n].k); din_q = mk_q(16*tbl[n].k); din_tag = TW'(tbl[n].k);
            @(posedge clk); #1;
            ei = tbl[n].e_valid ? mk_i(16*tbl[n].e_k) : '0;
            eq = tbl[n].e_valid ? mk_q(16*tbl[n].e_k) : '0;
            chk($sformatf("tbl%0d count", n), LW'(o_cnt),   LW'(tbl[n].e_cnt));
            chk($sformatf("tbl%0d full", n),  LW'(o_full),  LW'(tbl[n].e_full));
            chk($sformatf("tbl%0d empty", n), LW'(o_empty), LW'(tbl[n].e_empty));
            chk($sformatf("tbl%0d valid", n), LW'(o_valid), LW'(tbl[n].e_valid));
            chk($sformatf("tbl%0d unf", n),   LW'(o_unf),   LW'(tbl[n].e_unf));
            chk($sformatf("tbl%0d ovf", n),   LW'(o_ovf),   '0);
            chk($sformatf("tbl%0d dout_i", n), o_i, ei);
            chk($sformatf("tbl%0d dout_q", n), o_q, eq);
            chk($sformatf("tbl%0d tag", n),   LW'(o_tag),
                tbl[n].e_valid ? LW'(tbl[n].e_k) : '0);
        end
        mq.delete(); m_ovf = 0; m_unf = 1; m_valid = 0; m_out = '0;

        // Flush with push and pop active while holding 7 entries and a set underflow flag.
        for (int k = 0; k < 7; k++) push_k(k, "clr fill");
        drive(1, 1, 1, mk_i(300), mk_q(300), 5'd9, "clr");

        // Simultaneous push/pop while full keeps count and returns oldest data.
        for (int k = 0; k < 16; k++) push_k(k, "fill");
        for (int j = 0; j < 5; j++) drive(1, 1, 0, mk_i(100), mk_q(100), TW'(20+j), "full pp");
        for (int j = 0; j < 16; j++) drive(0, 1, 0, '0, '0, '0, "drain1");

        // Underflow on empty, then overflow on full with a value that must never appear.
        drive(0, 1, 0, '0, '0, '0, "empty pop");
        for (int k = 0; k < 16; k++) push_k(k, "fill2");
        drive(1, 0, 0, mk_i(77), mk_q(77), 5'd31, "ovf push");
        for (int j = 0; j < 16; j++) drive(0, 1, 0, '0, '0, '0, "drain2");

        // Async reset mid-operation while a popped entry is on the output.
        for (int k = 0; k < 3; k++) push_k(k, "pre rst");
        drive(0, 1, 0, '0, '0, '0, "pre rst pop");
        push = 0; pop = 0;
        #2 rstn = 1'b0;
        #1;
        chk("arst count", LW'(o_cnt),   '0);
        chk("arst empty", LW'(o_empty), LW'(1));
        chk("arst valid", LW'(o_valid), '0);
        chk("arst dout",  o_i,          '0);
        chk("arst flags", LW'({o_ovf, o_unf}), '0);
        #3 rstn = 1'b1;
        mq.delete(); m_ovf = 0; m_unf = 0; m_valid = 0; m_out = '0;
        @(posedge clk); #1;

        // Random traffic: fill-biased half then drain-biased half, rare flushes.
        for (int c = 0; c < 200; c++) begin
            p = (c < 100) ? ($urandom % 4 != 0) : ($urandom % 4 == 0);
            r = (c < 100) ? ($urandom % 4 == 0) : ($urandom % 4 != 0);
            drive(p, r, ($urandom % 64) == 0, rnd_vec(), rnd_vec(), TW'($urandom),
                  $sformatf("rnd%0d", c));
        end
        push = 0; pop = 0; clr = 0;

        // Depth-5 instance: FIFO order across pointer wrap.
        pushed = 0; npop5 = 0;
        for (int c = 0; c < 300 && (pushed < 23 || q5m.size() > 0); c++) begin
            p = (pushed < 23) && ($urandom % 4 != 0);
            r = (pushed == 23) ? 1'b1 : 1'($urandom % 2);
            push5 = p; pop5 = r;
            din_i = mk_i(16*pushed); din_q = mk_q(16*pushed); din_tag = TW'(pushed);
            popok  = r && q5m.size() > 0;
            pushok = p && (q5m.size() < D5 || popok);
            expk = popok ? q5m.pop_front() : 0;
            if (pushok) begin
                q5m.push_back(pushed);
                pushed++;
            end
            @(posedge clk); #1;
            if (v5) npop5++;
            chk("d5 count", LW'(c5), LW'(q5m.size()));
            chk("d5 full",  LW'(f5), LW'(q5m.size() == D5));
            chk("d5 valid", LW'(v5), LW'(popok));
            chk("d5 dout_i", i5,      popok ? mk_i(16*expk) : '0);
            chk("d5 dout_q", q5o,     popok ? mk_q(16*expk) : '0);
            chk("d5 tag",    LW'(t5), popok ? LW'(expk) : '0);
        end
        push5 = 0; pop5 = 0;
        chk("d5 total pops", LW'(npop5), LW'(23));
        chk("d5 final empty", LW'(e5), LW'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/cbfp_delay_buf.md
Name: cbfp_delay_buf

Overview:
- Parametrised successor to the fixed 16x16 CBFP shift register: a multi-lane I/Q circular buffer with explicit occupancy, full/empty status and a per-entry block-exponent tag.
- Sits between the FFT butterfly output and the CBFP normaliser. Holds sample blocks until their block exponent is known, then releases them oldest-first on pop.
- Registered output; no pop on empty, no silent overwrite when full.

Parameters:
- DATA_WIDTH, 9, signed bits per I or Q sample
- NUM_LANES, 16, parallel I/Q lanes per entry
- MAX_DEPTH, 16, entry count; any value >= 2, not required to be a power of two
- TAG_WIDTH, 5, unsigned side-band tag (block exponent) stored with each entry
- CNT_W, $clog2(MAX_DEPTH+1), derived width of count; not to be overridden

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous flush; priority over push and pop
- push  in  1  write request for din_i/din_q/din_tag
- din_i  in  NUM_LANES x DATA_WIDTH  signed I samples
- din_q  in  NUM_LANES x DATA_WIDTH  signed Q samples
- din_tag  in  TAG_WIDTH  tag stored with the entry
- pop  in  1  read request for the oldest entry
- dout_valid  out  1  dout_* carries a popped entry this cycle
- dout_i  out  NUM_LANES x DATA_WIDTH  popped I samples; 0 when dout_valid=0
- dout_q  out  NUM_LANES x DATA_WIDTH  popped Q samples; 0 when dout_valid=0
- dout_tag  out  TAG_WIDTH  popped tag; 0 when dout_valid=0
- count  out  CNT_W  current occupancy, 0..MAX_DEPTH
- full  out  1  count == MAX_DEPTH
- empty  out  1  count == 0
- overflow  out  1  sticky: a push was rejected
- underflow  out  1  sticky: a pop was rejected

Behaviour:
- Reset: all outputs 0, except empty = 1. wr_ptr = rd_ptr = 0, count = 0. Storage array is not reset.
- Accept rules:
  - push_acc = push & (~full | pop_acc)
  - pop_acc = pop & ~empty
  - Evaluate pop_acc first; push_acc depends on it.
- Write: on push_acc, mem[wr_ptr] <= {din_i, din_q, din_tag}. wr_ptr increments and wraps from MAX_DEPTH-1 to 0.
- Read: on pop_acc, the entry at rd_ptr is registered into dout_* and dout_valid is set. rd_ptr increments with the same wrap.
- Pop latency: pop at edge N; data is visible after edge N until edge N+1, one cycle, with dout_valid = 1. Otherwise dout_* = 0 and dout_valid = 0.
- count update:
  - +1 on push_acc only
  - -1 on pop_acc only
  - unchanged on both or neither
- full and empty are decoded combinationally from the registered count.
- Empty + push + pop: push accepted, pop rejected (no bypass), underflow set, count becomes 1.
- Full + push + pop: both accepted, count stays MAX_DEPTH. Popped data is the oldest entry, never the incoming one.
- Full + push, no pop: data dropped, overflow set, state unchanged.
- Empty + pop, no push: underflow set, dout_valid = 0.
- clr = 1:
  - pointers, count, dout_*, dout_valid, overflow and underflow all go to 0 at the next edge
  - push and pop in the same cycle are ignored and do not set the flags
- Sticky flags are cleared only by rstn or clr.
- Async reset mid-operation: immediate return to reset state; stored entries become unreachable.
- Signed data passes through bit-exact; no arithmetic, saturation or reordering of lanes.

Decomposition:
- Package cbfp_pkg:
  - default DATA_WIDTH, NUM_LANES, TAG_WIDTH localparams
  - typedef of a signed sample
  - typedef of the lane vector (NUM_LANES x sample)
  - packed entry struct {i vector, q vector, tag}
- Sub-module cbfp_buf_ctrl: owns pointers, wrap logic, count, accept logic and sticky flags. Outputs wr_en, rd_en, wr_ptr, rd_ptr.
- Top level: holds the storage array and the output register.

Test Plan:
- Reset, then push 16 entries with din_i[l] = 16k+l, din_q[l] = -(16k+l), tag = k -> count = 16, full = 1, dout_valid stays 0, all dout_* = 0.
- From full, pop 16 consecutive cycles -> dout_i[0] = 0,16,...,240 and tag = 0..15, each one cycle after its pop. Then empty = 1, no flags.
- Full, push and pop together for 5 cycles with din_i = 100+l -> count stays 16, outputs entries k = 0..4. Later pops return the remaining 11 old entries, then five 100-series entries.
- Empty, pop -> underflow = 1, dout_valid = 0. Full, push without pop -> overflow = 1, count stays 16, dropped value never appears on dout.
- MAX_DEPTH = 5 instance, 23 push/pop-interleaved entries -> FIFO order is preserved across pointer wrap and matches a queue model.
- clr asserted with push = pop = 1 and count = 7 -> next cycle count = 0, empty = 1, flags = 0, dout_valid = 0. A random push/pop sequence of 200 cycles on the default instance matches a queue model, including DATA_WIDTH-extreme values -256 and 255.
